// File: rtl/sms_dot_line_arbiter_if.sv
// Handshake bundle between the dotted-line requesters and the arbiter.
// The master side drives requests and the sensed line; the arbiter is the slave.
interface sms_dot_line_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic             line_sense;
    logic [N_REQ-1:0] gnt;
    logic             drive_en;
    logic [2:0]       owner;
    logic             busy;
    logic             timeout;
    logic             fault;

    modport master (
        output req, done, line_sense,
        input  gnt, drive_en, owner, busy, timeout, fault
    );

    modport slave (
        input  req, done, line_sense,
        output gnt, drive_en, owner, busy, timeout, fault
    );
endinterface

// File: rtl/sms_dot_line_arbiter.sv
// Round-robin, one-hot owner arbiter for a shared open-collector control line,
// with break-before-make gap, hold timeout and sticky stray-pull fault flag.
module sms_dot_line_arbiter #(
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 2,
    parameter int MAX_HOLD   = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    sms_dot_line_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [HW-1:0]    HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [GW-1:0]    GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [IW-1:0]    LAST_IDX  = IW'(N_REQ - 1);
    localparam logic [IW:0]      NREQ_W    = (IW+1)'(N_REQ);
    localparam logic [N_REQ-1:0] ONE       = N_REQ'(1);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    owner_q, owner_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             timeout_q, timeout_d;
    logic             fault_q, fault_d;

    logic             pick_vld;
    logic [IW-1:0]    pick_idx;
    logic [IW:0]      sum;

    // Walk offsets from the far end so the smallest offset from ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        sum      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + (IW+1)'(k);
            if (sum >= NREQ_W) sum = sum - NREQ_W;
            if (bus.req[sum[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = sum[IW-1:0];
            end
        end
    end

    logic release_now;
    assign release_now = !bus.req[owner_q] || bus.done[owner_q];

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        timeout_d = 1'b0;
        // Nobody should pull the line unless a grant is active.
        fault_d   = fault_q | ((state_q != GRANT) && !bus.line_sense);
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = GRANT;
                    gnt_d   = ONE << pick_idx;
                    owner_d = pick_idx;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (release_now || hold_q == HOLD_LAST) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    gap_d     = '0;
                    ptr_d     = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                    timeout_d = !release_now;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            gap_q     <= '0;
            timeout_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            timeout_q <= timeout_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.drive_en = |gnt_q;
    assign bus.owner    = 3'(owner_q);
    assign bus.busy     = (state_q != IDLE);
    assign bus.timeout  = timeout_q;
    assign bus.fault    = fault_q;
endmodule
